// File: rtl/pgm_ddram_arb.sv
// pgm_ddram_arb: round-robin arbiter sharing one DDRAM read port among three read clients.
// Optional WAIT timeout is built only when PGM_DDRAM_ARB_TIMEOUT_EN is defined.
module pgm_ddram_arb #(
  parameter int ADDR_W  = 29,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_rd,
  input  logic [ADDR_W-1:0] c0_addr,
  output logic              c0_ready,
  input  logic              c1_rd,
  input  logic [ADDR_W-1:0] c1_addr,
  output logic              c1_ready,
  input  logic              c2_rd,
  input  logic [ADDR_W-1:0] c2_addr,
  output logic              c2_ready,
  output logic [DATA_W-1:0] cli_dout,
  output logic              ddram_rd,
  output logic [ADDR_W-1:0] ddram_addr,
  input  logic [DATA_W-1:0] ddram_dout,
  input  logic              ddram_busy,
  input  logic              ddram_dout_ready,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
  localparam logic [1:0] NONE = 2'd3;

  state_t     state, state_nxt;
  logic [1:0] rr_ptr, mask, pick, slot;
  logic       pick_valid, done, tmo_hit;
  logic [2:0] req, ready;

  assign req = {c2_rd, c1_rd, c0_rd};
  assign {c2_ready, c1_ready, c0_ready} = ready;

  function automatic logic [1:0] rr_slot(input logic [1:0] base, input logic [1:0] ofs);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, ofs};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    return 3'b001;
      2'd1:    return 3'b010;
      2'd2:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  // Search rr_ptr, rr_ptr+1, rr_ptr+2; iterating backwards lets the nearest slot win.
  always_comb begin
    pick_valid = 1'b0;
    pick       = NONE;
    slot       = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      slot = rr_slot(rr_ptr, 2'(i));
      if (req[slot] && (slot != mask)) begin
        pick_valid = 1'b1;
        pick       = slot;
      end
    end
  end

`ifdef PGM_DDRAM_ARB_TIMEOUT_EN
  localparam logic [9:0] TMO_LIMIT = 10'(TIMEOUT);
  logic [9:0] wait_cnt;

  // Cycles spent in WAIT; held at zero while the command is being issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               wait_cnt <= 10'd0;
    else if (state == ISSUE) wait_cnt <= 10'd0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 10'd1;
    else                     wait_cnt <= wait_cnt;
  end

  assign tmo_hit = (state == WAIT) && (wait_cnt == TMO_LIMIT);
`else
  assign tmo_hit = 1'b0;
`endif

  assign done = (state == WAIT) && (ddram_dout_ready || tmo_hit);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ISSUE; else state_nxt = IDLE;
      ISSUE:   if (!ddram_busy) state_nxt = WAIT; else state_nxt = ISSUE;
      WAIT:    if (done) state_nxt = IDLE; else state_nxt = WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs plus round-robin pointer and re-grant mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant       <= NONE;
      ddram_rd    <= 1'b0;
      ddram_addr  <= '0;
      cli_dout    <= '0;
      ready       <= 3'b000;
      timeout_err <= 1'b0;
      rr_ptr      <= 2'd0;
      mask        <= NONE;
    end else begin
      ready       <= 3'b000;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          mask <= NONE;
          if (pick_valid) begin
            grant    <= pick;
            ddram_rd <= 1'b1;
            case (pick)
              2'd0:    ddram_addr <= c0_addr;
              2'd1:    ddram_addr <= c1_addr;
              default: ddram_addr <= c2_addr;
            endcase
          end
        end
        ISSUE: begin
          if (!ddram_busy) ddram_rd <= 1'b0;
        end
        WAIT: begin
          // A timed-out transaction still completes, with zero data and an error pulse.
          if (done) begin
            cli_dout    <= ddram_dout_ready ? ddram_dout : '0;
            timeout_err <= ~ddram_dout_ready;
            ready       <= onehot(grant);
            grant       <= NONE;
            rr_ptr      <= rr_slot(grant, 2'd1);
            mask        <= grant;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
